// File: rtl/idmem_pkg.sv
// Shared types and constants for the unified instruction/data memory responder.
package idmem_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/idmem_if.sv
// Request/response bundle between the multicycle core and the memory responder.
interface idmem_if;
    import idmem_pkg::*;

    logic              req;
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              ready;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, err
    );
endinterface

// File: rtl/idmem_array.sv
// Single-port word array: combinational read by index, write on posedge.
module idmem_array
    import idmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IW          = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [IW-1:0]     i_idx,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);
    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_idx] <= i_wdata;
    end

    assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/idmem_responder.sv
// Memory responder FSM with programmable wait states.
// Optional misaligned-access trap: define IDMEM_MISALIGN_TRAP_EN.
module idmem_responder
    import idmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    idmem_if.slave bus
);
    localparam int IW = idx_w(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic              r_mis;
    logic [IW-1:0]     r_idx;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_rdata;
    logic              w_req_mis;
    logic              w_arr_we;
    logic [WORD_W-1:0] w_arr_rdata;

`ifdef IDMEM_MISALIGN_TRAP_EN
    assign w_req_mis = (bus.addr[1:0] != 2'b00);
`else
    assign w_req_mis = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.req) w_next = WAIT;
            WAIT:    if (r_cnt == WS) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_mis   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.req) begin
                r_we    <= bus.we;
                r_mis   <= w_req_mis;
                r_idx   <= bus.addr[2 +: IW];
                r_wdata <= bus.wdata;
                r_cnt   <= '0;
            end
            if (r_state == WAIT) begin
                if (r_cnt != WS) r_cnt <= r_cnt + 1'b1;
                // Read data is captured on entry to DONE and held afterwards.
                if (r_cnt == WS) begin
                    if (r_mis)     r_rdata <= '0;
                    else if (!r_we) r_rdata <= w_arr_rdata;
                end
            end
        end
    end

    assign w_arr_we = (r_state == DONE) && r_we && !r_mis;

    idmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IW         (IW)
    ) u_array (
        .i_clk  (i_clk),
        .i_we   (w_arr_we),
        .i_idx  (r_idx),
        .i_wdata(r_wdata),
        .o_rdata(w_arr_rdata)
    );

    assign bus.ready = (r_state == DONE);
    assign bus.err   = (r_state == DONE) && r_mis;
    assign bus.rdata = r_rdata;
endmodule

// File: tb/tb_idmem_responder.sv
// Scoreboard bench for idmem_responder: random traffic against a word-array model.
module tb_idmem_responder;
    localparam int WS    = 2;
    localparam int DEPTH = 256;

`ifdef IDMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        bit          rd;
        bit          known;
        bit          err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   next_free = 0;

    exp_t        q[$];
    logic [31:0] mem[DEPTH];
    bit          vld[DEPTH];

    idmem_if bus ();
    idmem_if bus0 ();

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    idmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(WS)
    ) u_dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    idmem_responder #(
        .DEPTH_WORDS(16),
        .WAIT_STATES(0)
    ) u_dut0 (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus0)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int widx(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    // Drive one cycle of request at a negedge; the model decides acceptance.
    task automatic issue(input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, output bit acc);
        exp_t e;
        int   i;
        bit   mis;
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = wd;
        acc = (cyc + 1 >= next_free);
        if (acc) begin
            i       = widx(addr);
            mis     = TRAP && (addr % 4 != 0);
            e.rd    = !we;
            e.err   = mis;
            e.known = mis || vld[i];
            e.data  = mis ? 32'h0 : mem[i];
            e.cyc   = cyc + 1 + WS + 1;
            if (we && !mis) begin
                mem[i] = wd;
                vld[i] = 1'b1;
            end
            next_free = cyc + 1 + WS + 3;
            q.push_back(e);
        end
    endtask

    task automatic access(input bit we, input logic [31:0] addr,
                          input logic [31:0] wd);
        bit acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) issue(we, addr, wd, acc);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept: request at %h never accepted", addr);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.req = 1'b0;
        end
    endtask

    task automatic b_access(input bit we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp);
        int  c0;
        bit  seen = 1'b0;
        @(negedge clk);
        bus0.req   = 1'b1;
        bus0.we    = we;
        bus0.addr  = addr;
        bus0.wdata = wd;
        c0 = cyc;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            bus0.req = 1'b0;
            seen = (bus0.ready === 1'b1);
        end
        check("ws0_ready_seen", 32'(seen), 32'd1);
        check("ws0_latency", 32'(cyc - c0), 32'd2);
        if (!we) check("ws0_rdata", bus0.rdata, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_ready: expected at cycle %0d, got ready=0", e.cyc);
            end
            if (bus.ready === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_ready: got ready=1 expected none at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    check("ready_cycle", 32'(cyc), 32'(e.cyc));
                    check("err", 32'(bus.err), 32'(e.err));
                    if (e.rd && e.known) check("rdata", bus.rdata, e.data);
                end
            end else if (bus.err !== 1'b0) begin
                check("err_idle", 32'(bus.err), 32'd0);
            end
        end
    end

    initial begin
        bit          acc;
        bit          we;
        logic [31:0] a;
        logic [31:0] old;
        bit          oldv;
        int          i;

        bus.req = 1'b0;  bus.we = 1'b0;  bus.addr = '0;  bus.wdata = '0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_rdata", bus.rdata, 32'h0);
        rst = 1'b0;
        next_free = cyc + 1;

        access(1'b1, 32'h10, 32'hDEADBEEF);
        access(1'b0, 32'h10, 32'h0);
        access(1'b1, 32'h20, 32'hCAFEF00D);
        access(1'b1, 32'h400, 32'hA5A5A5A5);
        access(1'b0, 32'h000, 32'h0);
        access(1'b1, 32'h13, 32'h11223344);
        access(1'b0, 32'h10, 32'h0);
        idle(2);

        // Reset during the WAIT phase of a write must discard the write.
        i = widx(32'h20);
        old = mem[i];
        oldv = vld[i];
        access(1'b1, 32'h20, 32'h12345678);
        idle(2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(bus.ready), 32'd0);
        check("midrst_err", 32'(bus.err), 32'd0);
        check("midrst_rdata", bus.rdata, 32'h0);
        rst = 1'b0;
        void'(q.pop_back());
        mem[i] = old;
        vld[i] = oldv;
        next_free = cyc + 1;
        access(1'b0, 32'h20, 32'h0);

        // Request held high with a fresh read address every cycle.
        for (int k = 0; k < 25; k++)
            issue(1'b0, 32'($urandom_range(0, 255)) * 4, 32'h0, acc);
        idle(1);

        for (int k = 0; k < 60; k++) begin
            we = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 2047));
            if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
            access(we, a, $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(1);

        for (int k = 0; k < 100 && q.size() > 0; k++) @(negedge clk);
        check("drain", 32'(q.size()), 32'd0);

        b_access(1'b1, 32'h8, 32'h0BADF00D, 32'h0);
        b_access(1'b0, 32'h8, 32'h0, 32'h0BADF00D);
        b_access(1'b0, 32'h48, 32'h0, 32'h0BADF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
